uart_tx_fifo_ctrl: RTL

Buffered UART transmitter. It is the transmit-side counterpart of the existing UART receive path in the demo designs. Bytes are pushed through a valid/ready handshake into a small internal FIFO, then serialized as 8N1 frames on UART_TX_o at the configured baud rate. Sits beside the receiver in top-level demos, for echo, status reporting and loopback.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_byte_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the transmit and receive paths:
//               line-level constants, transmitter state encoding and the
//               baud divider calculation.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // One start bit, eight data bits, one stop bit
    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per line bit; truncation is intentional (156 at 18 MHz / 115200)
    function automatic int calc_divider(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_fifo
// Description : Single-clock synchronous FIFO with occupancy counter.
//               Pointers wrap modulo DEPTH (power of 2). Head entry is
//               presented combinationally on o_data.
// Ports       : clk, rst      clock, asynchronous active-high reset
//               i_push/i_data  write request and data (ignored when full)
//               i_pop          read request (ignored when empty)
//               o_data         head entry
//               o_full/o_empty occupancy flags
//               o_level        occupancy, 0..DEPTH
// Revision    : 1.0  initial release
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == (c_AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // Power-of-2 depth: natural overflow of the pointer is the wrap
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_ctrl
// Description : Buffered 8N1 UART transmitter. Bytes enter a small FIFO via
//               a valid/ready handshake and are serialized LSB first.
// Ports       : CLK_IN     system clock
//               RST_IN     asynchronous active-high reset
//               DATA_i     byte to transmit
//               VALID_i    DATA_i valid
//               READY_o    FIFO can accept a byte this cycle
//               UART_TX_o  serial line, idle high (registered)
//               BUSY_o     frame in progress or FIFO non-empty (registered)
//               LEVEL_o    FIFO occupancy
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 18_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK_IN,
    input  logic                          RST_IN,
    input  logic [7:0]                    DATA_i,
    input  logic                          VALID_i,
    output logic                          READY_o,
    output logic                          UART_TX_o,
    output logic                          BUSY_o,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL_o
);

    localparam int c_DIVIDER = calc_divider(CLK_FREQ, BAUDRATE);
    localparam int c_CW      = (c_DIVIDER > 1) ? $clog2(c_DIVIDER) : 1;
    localparam int c_LW      = $clog2(FIFO_DEPTH) + 1;

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [c_CW-1:0]   r_baud_cnt;
    logic [c_CW-1:0]   w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              w_push;
    logic              w_pop;
    logic              w_baud_done;
    logic [7:0]        w_fifo_data;
    logic              w_full;
    logic              w_empty;
    logic [c_LW-1:0]   w_level;
    logic [c_LW-1:0]   w_level_next;

    // READY depends only on registered occupancy, so a pop in the same
    // cycle as full does not open the slot until the next cycle.
    assign READY_o     = !w_full;
    assign w_push      = VALID_i && !w_full;
    assign w_baud_done = (r_baud_cnt == c_CW'(c_DIVIDER - 1));
    assign UART_TX_o   = r_tx;
    assign BUSY_o      = r_busy;
    assign LEVEL_o     = w_level;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (CLK_IN),
        .rst     (RST_IN),
        .i_push  (w_push),
        .i_data  (DATA_i),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= STOP_BIT;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud_cnt + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;

        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_fifo_data;
                    w_bit_idx_next = '0;
                    w_state_next   = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit when data waits
                    if (!w_empty) begin
                        w_pop          = 1'b1;
                        w_shift_next   = w_fifo_data;
                        w_bit_idx_next = '0;
                        w_state_next   = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
        endcase

        // Line level follows the state being entered, so the registered
        // output changes on the same edge as the state.
        case (w_state_next)
            START:   w_tx_next = START_BIT;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = STOP_BIT;
        endcase

        w_level_next = w_level + c_LW'(w_push) - c_LW'(w_pop);
        w_busy_next  = (w_state_next != IDLE) || (w_level_next != '0);
    end

endmodule
`default_nettype wire
